line_stream_feeder: RTL and testbench
=====================================

Name: line_stream_feeder

Overview:
- Producer side of the three-row pixel interface consumed by the 3x3 mask register block.
- Accepts a raster-order pixel stream, one pixel per valid cycle, and keeps the two previous image lines in internal line memories.
- Emits three vertically aligned pixels per column: `out_1` is the current line, `out_2` is the line above, `out_3` is two lines above. Emits `read_ready` when the triple is valid.
- Sits between the image input interface and the mask register block, ahead of the CeNN cell array.

Parameters:
- width, 8, pixel bit width.
- img_w, 16, pixels per line (columns); must be >= 3.
- img_h, 16, lines per frame (rows); must be >= 3.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- sof  input  1  start of frame; restarts the frame.
- pix_valid  input  1  `pix_in` carries a valid pixel this cycle.
- pix_in  input  width  raster-order input pixel.
- out_1  output  width  pixel of the current line at the current column.
- out_2  output  width  pixel one line above, same column.
- out_3  output  width  pixel two lines above, same column.
- read_ready  output  1  `out_1`..`out_3` hold a valid vertical triple.
- row_idx  output  $clog2(img_h)  row of the last accepted pixel.
- col_idx  output  $clog2(img_w)  column of the last accepted pixel.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame.

Behaviour:
- Reset (`rst_n`=0 at a clk edge):
  - `out_1`/`out_2`/`out_3`=0, `read_ready`=0, `frame_done`=0, `row_idx`=0, `col_idx`=0.
  - FSM goes to FILL and the internal column/row counters are cleared.
  - Line memory contents are not cleared.
- Line memories: `lineA` holds the previous line and `lineB` the line before it, img_w entries each, indexed by column counter `c`.
- Accepted pixel (`pix_valid`=1, `sof`=0), all in one cycle (latency 1):
  - `out_1`<=`pix_in`, `out_2`<=`lineA[c]`, `out_3`<=`lineB[c]`.
  - `lineB[c]`<=`lineA[c]`, `lineA[c]`<=`pix_in` (read-before-write, same address).
  - `row_idx`<=`r`, `col_idx`<=`c`.
- Counters: `c` increments per accepted pixel. At `c`=img_w-1, `c` wraps to 0 and `r` increments. At `r`=img_h-1 and `c`=img_w-1, both wrap to 0.
- FSM states:
  - FILL: rows 0 and 1; outputs update, `read_ready`<=0. Moves to STREAM on the pixel at `r`=1, `c`=img_w-1.
  - STREAM: rows 2..img_h-1; `read_ready`<=1 for every accepted pixel. Moves to DONE on the pixel at `r`=img_h-1, `c`=img_w-1.
  - DONE: one cycle; `frame_done`=1, `read_ready`=0, then back to FILL. A `pix_valid` in the DONE cycle is accepted as row 0, col 0 of the next frame.
- No accepted pixel (`pix_valid`=0): `read_ready`<=0; `out_*`, `row_idx`, `col_idx` hold; counters and memories hold.
- `sof`=1 (any state, priority over `pix_valid`):
  - Counters go to 0, FSM to FILL, `read_ready`<=0, `frame_done`<=0.
  - The pixel on `pix_in` that cycle is dropped; `sof` precedes the first pixel.
- Reset mid-line: behaves as `sof`, and the outputs are also cleared.
- `frame_done` and `read_ready` are never high in the same cycle.
- `read_ready` high count per frame = (img_h-2)*img_w.
- No backpressure: the consumer must accept every `read_ready` cycle.

Test Plan:
- img_w=4, img_h=4; reset, then stream pixels with value 4r+c+1 continuously -> `read_ready` low for the first 8 pixels. The cycle after pixel 9 (r2,c0) gives `out_1`=9, `out_2`=5, `out_3`=1 with `read_ready`=1. Pixel 16 gives 16/12/8. `frame_done` pulses once, in the cycle after the `read_ready` of pixel 16.
- Same frame with `pix_valid` toggled 1,0,1,0 -> `read_ready` is high only on the cycles following valid pixels, `out_*` hold through the gaps, and the triples match the continuous case.
- Two back-to-back frames with the second frame's pixels = first frame's values + 100 -> frame 2, row 2, col 0 gives `out_1`=109, `out_2`=105, `out_3`=101. `read_ready` is low for frame 2 rows 0-1 despite the stale memories.
- Assert `sof` after 10 pixels, then restart the frame -> `read_ready`=0 for the next 8 accepted pixels, and `row_idx`/`col_idx` restart at 0,0.
- Assert `rst_n`=0 mid-row 2 for one cycle -> next cycle all outputs are 0, then the FILL sequence repeats.
- Full img_w=16, img_h=16 random frame checked against a reference model -> exactly 224 `read_ready` pulses, every triple correct, and `frame_done` pulses once.

Source files
------------

// File: rtl/line_stream_feeder_if.sv
// Pixel stream in, vertical pixel triples out.
// Source side is master; the feeder is slave.
interface line_stream_feeder_if #(
  parameter int width = 8,
  parameter int img_w = 16,
  parameter int img_h = 16
);
  localparam int CW = $clog2(img_w);
  localparam int RW = $clog2(img_h);

  logic             sof;
  logic             pix_valid;
  logic [width-1:0] pix_in;
  logic [width-1:0] out_1;
  logic [width-1:0] out_2;
  logic [width-1:0] out_3;
  logic             read_ready;
  logic [RW-1:0]    row_idx;
  logic [CW-1:0]    col_idx;
  logic             frame_done;

  modport master (
    output sof, pix_valid, pix_in,
    input  out_1, out_2, out_3,
    input  read_ready, row_idx, col_idx,
    input  frame_done
  );

  modport slave (
    input  sof, pix_valid, pix_in,
    output out_1, out_2, out_3,
    output read_ready, row_idx, col_idx,
    output frame_done
  );
endinterface

// File: rtl/line_stream_feeder.sv
// Two line memories turn a raster stream into
// column-aligned triples for the 3x3 mask block.
module line_stream_feeder #(
  parameter int width = 8,
  parameter int img_w = 16,
  parameter int img_h = 16
) (
  input  logic clk,
  input  logic rst_n,
  line_stream_feeder_if.slave bus
);
  localparam int CW = $clog2(img_w);
  localparam int RW = $clog2(img_h);

  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [CW-1:0] C_LAST = CW'(img_w - 1);
  localparam logic [RW-1:0] R_LAST = RW'(img_h - 1);
  localparam logic [RW-1:0] R_ONE  = RW'(1);

  logic [width-1:0] line_a_q [img_w];
  logic [width-1:0] line_b_q [img_w];

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    c_q, c_d;
  logic [RW-1:0]    r_q, r_d;
  logic [width-1:0] o1_q, o1_d;
  logic [width-1:0] o2_q, o2_d;
  logic [width-1:0] o3_q, o3_d;
  logic             rr_q, rr_d;
  logic             fd_q, fd_d;
  logic [CW-1:0]    ci_q, ci_d;
  logic [RW-1:0]    ri_q, ri_d;

  logic accept;
  logic col_end;
  logic frm_end;

  assign accept  = bus.pix_valid & ~bus.sof;
  assign col_end = (c_q == C_LAST);
  assign frm_end = col_end && (r_q == R_LAST);

  // Next state: sof restarts, DONE lasts one
  // cycle and may already take pixel (0,0).
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    o1_d    = o1_q;
    o2_d    = o2_q;
    o3_d    = o3_q;
    ci_d    = ci_q;
    ri_d    = ri_q;
    rr_d    = 1'b0;
    fd_d    = 1'b0;
    if (bus.sof) begin
      state_d = FILL;
      c_d     = '0;
      r_d     = '0;
    end else begin
      if (state_q != FILL && state_q != STREAM) begin
        fd_d    = (state_q == DONE);
        state_d = FILL;
      end
      if (accept) begin
        o1_d = bus.pix_in;
        o2_d = line_a_q[c_q];
        o3_d = line_b_q[c_q];
        ri_d = r_q;
        ci_d = c_q;
        if (col_end) begin
          c_d = '0;
          r_d = (r_q == R_LAST) ? '0 : r_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
        unique case (1'b1)
          (state_q == FILL): begin
            if (col_end && r_q == R_ONE)
              state_d = STREAM;
          end
          (state_q == STREAM): begin
            rr_d = 1'b1;
            if (frm_end)
              state_d = DONE;
          end
          default: ;
        endcase
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      c_q     <= '0;
      r_q     <= '0;
      o1_q    <= '0;
      o2_q    <= '0;
      o3_q    <= '0;
      ci_q    <= '0;
      ri_q    <= '0;
      rr_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      r_q     <= r_d;
      o1_q    <= o1_d;
      o2_q    <= o2_d;
      o3_q    <= o3_d;
      ci_q    <= ci_d;
      ri_q    <= ri_d;
      rr_q    <= rr_d;
      fd_q    <= fd_d;
    end
  end

  // Line shift at column c: A moves to B,
  // new pixel lands in A. Never cleared.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      line_b_q[c_q] <= line_a_q[c_q];
      line_a_q[c_q] <= bus.pix_in;
    end
  end

  assign bus.out_1      = o1_q;
  assign bus.out_2      = o2_q;
  assign bus.out_3      = o3_q;
  assign bus.read_ready = rr_q;
  assign bus.frame_done = fd_q;
  assign bus.row_idx    = ri_q;
  assign bus.col_idx    = ci_q;
endmodule

// File: tb/tb_line_stream_feeder.sv
// Bench for line_stream_feeder: 4x4 directed
// frames plus a random 16x16 frame.
module tb_line_stream_feeder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_stream_feeder_if #(.width(8), .img_w(4), .img_h(4)) bs ();
  line_stream_feeder_if #(.width(8), .img_w(16), .img_h(16)) bb ();

  line_stream_feeder #(.width(8), .img_w(4), .img_h(4)) u_s (
    .clk(clk), .rst_n(rst_n), .bus(bs)
  );
  line_stream_feeder #(.width(8), .img_w(16), .img_h(16)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bb)
  );

  int total = 0;
  int bad = 0;

  // Reference: raster position per frame plus
  // the last two pixels seen in each column.
  int mW [2] = '{4, 16};
  int mH [2] = '{4, 16};
  int mr [2];
  int mc [2];
  logic [7:0] hA [2][16];
  logic [7:0] hB [2][16];
  int hn [2][16];
  logic [7:0] e1 [2];
  logic [7:0] e2 [2];
  logic [7:0] e3 [2];
  bit ev2 [2];
  bit ev3 [2];
  bit err [2];
  bit efd [2];
  bit pend [2];
  int eri [2];
  int eci [2];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int j, input bit s, input bit v,
                       input logic [7:0] p, input bit rn);
    bit was = pend[j];
    pend[j] = 1'b0;
    if (!rn) begin
      e1[j] = 0; e2[j] = 0; e3[j] = 0;
      ev2[j] = 1; ev3[j] = 1;
      err[j] = 0; efd[j] = 0;
      eri[j] = 0; eci[j] = 0;
      mr[j] = 0; mc[j] = 0;
    end else if (s) begin
      err[j] = 0; efd[j] = 0;
      mr[j] = 0; mc[j] = 0;
    end else begin
      efd[j] = was;
      err[j] = 0;
      if (v) begin
        int c = mc[j];
        e1[j] = p;
        e2[j] = hA[j][c];
        e3[j] = hB[j][c];
        ev2[j] = hn[j][c] >= 1;
        ev3[j] = hn[j][c] >= 2;
        hB[j][c] = hA[j][c];
        hA[j][c] = p;
        hn[j][c]++;
        eri[j] = mr[j];
        eci[j] = c;
        err[j] = mr[j] >= 2;
        if (mr[j] == mH[j] - 1 && c == mW[j] - 1) pend[j] = 1'b1;
        mc[j]++;
        if (mc[j] == mW[j]) begin
          mc[j] = 0;
          mr[j] = (mr[j] + 1) % mH[j];
        end
      end
    end
  endtask

  task automatic compare(input int j);
    logic [31:0] o1, o2, o3, rr, fd, ri, ci;
    string n = $sformatf("i%0d_", j);
    if (j == 0) begin
      o1 = 32'(bs.out_1); o2 = 32'(bs.out_2); o3 = 32'(bs.out_3);
      rr = 32'(bs.read_ready); fd = 32'(bs.frame_done);
      ri = 32'(bs.row_idx); ci = 32'(bs.col_idx);
    end else begin
      o1 = 32'(bb.out_1); o2 = 32'(bb.out_2); o3 = 32'(bb.out_3);
      rr = 32'(bb.read_ready); fd = 32'(bb.frame_done);
      ri = 32'(bb.row_idx); ci = 32'(bb.col_idx);
    end
    chk({n, "out_1"}, o1, 32'(e1[j]));
    if (ev2[j]) chk({n, "out_2"}, o2, 32'(e2[j]));
    if (ev3[j]) chk({n, "out_3"}, o3, 32'(e3[j]));
    chk({n, "read_ready"}, rr, 32'(err[j]));
    chk({n, "frame_done"}, fd, 32'(efd[j]));
    chk({n, "row_idx"}, ri, 32'(eri[j]));
    chk({n, "col_idx"}, ci, 32'(eci[j]));
  endtask

  task automatic step(input int i, input bit s, input bit v,
                      input logic [7:0] p, input bit rn);
    bit s0 = (i == 0) ? s : 1'b0;
    bit v0 = (i == 0) ? v : 1'b0;
    bit s1 = (i == 1) ? s : 1'b0;
    bit v1 = (i == 1) ? v : 1'b0;
    bs.sof = s0; bs.pix_valid = v0; bs.pix_in = p;
    bb.sof = s1; bb.pix_valid = v1; bb.pix_in = p;
    rst_n = rn;
    @(posedge clk);
    #1;
    model(0, s0, v0, p, rn);
    model(1, s1, v1, p, rn);
    compare(0);
    compare(1);
  endtask

  initial begin
    int rrc;
    int fdc;
    bs.sof = 0; bs.pix_valid = 0; bs.pix_in = 0;
    bb.sof = 0; bb.pix_valid = 0; bb.pix_in = 0;
    for (int j = 0; j < 2; j++) begin
      mr[j] = 0; mc[j] = 0; pend[j] = 0;
      ev2[j] = 0; ev3[j] = 0;
      for (int k = 0; k < 16; k++) begin
        hn[j][k] = 0; hA[j][k] = 0; hB[j][k] = 0;
      end
    end

    step(0, 0, 1, 8'hAA, 0);
    step(0, 0, 0, 8'h00, 0);

    for (int k = 0; k < 16; k++) begin
      step(0, 0, 1, 8'(k + 1), 1);
      if (k == 8) begin
        chk("cont_p9_out_1", 32'(bs.out_1), 9);
        chk("cont_p9_out_2", 32'(bs.out_2), 5);
        chk("cont_p9_out_3", 32'(bs.out_3), 1);
        chk("cont_p9_rr", 32'(bs.read_ready), 1);
      end
      if (k == 15) begin
        chk("cont_p16_out_1", 32'(bs.out_1), 16);
        chk("cont_p16_out_2", 32'(bs.out_2), 12);
        chk("cont_p16_out_3", 32'(bs.out_3), 8);
      end
    end
    step(0, 0, 0, 8'h00, 1);
    chk("cont_frame_done", 32'(bs.frame_done), 1);
    step(0, 0, 0, 8'h00, 1);

    for (int k = 0; k < 32; k++) begin
      if (k % 2 == 0) step(0, 0, 1, 8'(k / 2 + 1), 1);
      else step(0, 0, 0, 8'($urandom_range(0, 255)), 1);
      if (k == 17) chk("tog_gap_out_1", 32'(bs.out_1), 9);
    end
    step(0, 0, 0, 8'h00, 1);

    for (int k = 0; k < 32; k++) begin
      step(0, 0, 1, 8'(k < 16 ? k + 1 : k - 16 + 101), 1);
      if (k == 24) begin
        chk("b2b_out_1", 32'(bs.out_1), 109);
        chk("b2b_out_2", 32'(bs.out_2), 105);
        chk("b2b_out_3", 32'(bs.out_3), 101);
        chk("b2b_rr", 32'(bs.read_ready), 1);
      end
    end

    for (int k = 0; k < 10; k++)
      step(0, 0, 1, 8'($urandom_range(0, 255)), 1);
    step(0, 1, 1, 8'hEE, 1);
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 1, 8'(k + 1), 1);
      if (k == 0) begin
        chk("sof_row", 32'(bs.row_idx), 0);
        chk("sof_col", 32'(bs.col_idx), 0);
      end
    end
    step(0, 0, 0, 8'h00, 1);

    for (int k = 0; k < 9; k++)
      step(0, 0, 1, 8'($urandom_range(0, 255)), 1);
    step(0, 0, 1, 8'h55, 0);
    chk("rst_out_1", 32'(bs.out_1), 0);
    chk("rst_rr", 32'(bs.read_ready), 0);
    for (int k = 0; k < 16; k++)
      step(0, 0, 1, 8'($urandom_range(0, 255)), 1);
    step(0, 0, 0, 8'h00, 1);

    rrc = 0;
    fdc = 0;
    for (int k = 0; k < 256; k++) begin
      step(1, 0, 1, 8'($urandom_range(0, 255)), 1);
      if (bb.read_ready === 1'b1) rrc++;
      if (bb.frame_done === 1'b1) fdc++;
    end
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 8'h00, 1);
      if (bb.read_ready === 1'b1) rrc++;
      if (bb.frame_done === 1'b1) fdc++;
    end
    chk("big_rr_count", 32'(rrc), 224);
    chk("big_fd_count", 32'(fdc), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
